// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the native valid/ready memory bus.
// One transaction per grant, with a watchdog that ends hung slave accesses with a fault.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      resetn,

  input  logic                      m0_valid,
  input  logic [ADDR_WIDTH-1:0]     m0_addr,
  input  logic [DATA_WIDTH/8-1:0]   m0_wstrb,
  input  logic [DATA_WIDTH-1:0]     m0_wdata,
  output logic                      m0_ready,
  output logic [DATA_WIDTH-1:0]     m0_rdata,
  output logic                      m0_fault,

  input  logic                      m1_valid,
  input  logic [ADDR_WIDTH-1:0]     m1_addr,
  input  logic [DATA_WIDTH/8-1:0]   m1_wstrb,
  input  logic [DATA_WIDTH-1:0]     m1_wdata,
  output logic                      m1_ready,
  output logic [DATA_WIDTH-1:0]     m1_rdata,
  output logic                      m1_fault,

  output logic                      s_valid,
  output logic [ADDR_WIDTH-1:0]     s_addr,
  output logic [DATA_WIDTH/8-1:0]   s_wstrb,
  output logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic                      s_ready,
  input  logic [DATA_WIDTH-1:0]     s_rdata
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  // A zero timeout still needs a one-bit counter so the register stays legal.
  localparam int unsigned WD_WIDTH   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);
  localparam bit   WD_ENABLE  = (TIMEOUT_CYCLES != 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                owner;
  logic                owner_nxt;
  logic                last;
  logic                last_nxt;
  logic [WD_WIDTH-1:0] wd_cnt;
  logic [WD_WIDTH-1:0] wd_cnt_nxt;

  logic                busy;
  logic                own_valid;
  logic                own_done;
  logic                own_timeout;
  logic                own_finish;

  // Status of the granted transaction, shared by next-state and output logic.
  always_comb begin
    busy        = (state == ST_BUSY);
    own_valid   = owner ? m1_valid : m0_valid;
    own_done    = busy && own_valid && s_ready;
    own_timeout = busy && own_valid && !s_ready && WD_ENABLE && (wd_cnt == WD_LIMIT);
    own_finish  = own_done || own_timeout;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      wd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      last   <= last_nxt;
      wd_cnt <= wd_cnt_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, finish or abandon in BUSY.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    last_nxt   = last;
    wd_cnt_nxt = wd_cnt;
    case (state)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_nxt  = ST_BUSY;
          owner_nxt  = (m0_valid && m1_valid) ? ~last : m1_valid;
          wd_cnt_nxt = '0;
        end
      end
      ST_BUSY: begin
        if (!own_valid) begin
          // Owner withdrew its request: drop the grant without touching fairness.
          state_nxt = ST_IDLE;
        end else if (own_finish) begin
          state_nxt = ST_IDLE;
          last_nxt  = owner;
        end else if (WD_ENABLE && (wd_cnt != WD_LIMIT)) begin
          wd_cnt_nxt = wd_cnt + WD_WIDTH'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: slave side muxed from the owner, completion routed back to it only.
  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wstrb  = '0;
    s_wdata  = '0;
    m0_ready = 1'b0;
    m0_rdata = '0;
    m0_fault = 1'b0;
    m1_ready = 1'b0;
    m1_rdata = '0;
    m1_fault = 1'b0;
    if (busy) begin
      s_valid = own_valid && !own_timeout;
      s_addr  = owner ? m1_addr  : m0_addr;
      s_wstrb = owner ? m1_wstrb : m0_wstrb;
      s_wdata = owner ? m1_wdata : m0_wdata;
    end
    if (owner) begin
      m1_ready = own_finish;
      m1_fault = own_timeout;
      m1_rdata = own_done ? s_rdata : '0;
    end else begin
      m0_ready = own_finish;
      m0_fault = own_timeout;
      m0_rdata = own_done ? s_rdata : '0;
    end
  end

  logic unused_strb;
  assign unused_strb = (STRB_WIDTH == 0);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int          TMO = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    mv;
  logic [AW-1:0] ma [2];
  logic [SW-1:0] ms [2];
  logic [DW-1:0] md [2];
  logic          m0_ready, m1_ready, m0_fault, m1_fault;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_valid, s_ready;
  logic [AW-1:0] s_addr;
  logic [SW-1:0] s_wstrb;
  logic [DW-1:0] s_wdata, s_rdata;

  // Transaction-level model: who holds the bus, who won last, how long it has waited.
  int grant;
  int prev;
  int age;
  int checks;
  int errors;
  logic [1:0] got;
  logic       stuck;

  mem_bus_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(mv[0]), .m0_addr(ma[0]), .m0_wstrb(ms[0]), .m0_wdata(md[0]),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_fault(m0_fault),
    .m1_valid(mv[1]), .m1_addr(ma[1]), .m1_wstrb(ms[1]), .m1_wdata(md[1]),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_fault(m1_fault),
    .s_valid(s_valid), .s_addr(s_addr), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    grant = -1;
    prev  = 1;
    age   = 0;
  endtask

  // Advance the model across one clock edge using the inputs that were stable at it.
  task automatic model_step();
    if (grant < 0) begin
      if (mv == 2'b11)   grant = 1 - prev;
      else if (mv[0])    grant = 0;
      else if (mv[1])    grant = 1;
      age = 0;
    end else if (!mv[grant]) begin
      grant = -1;
    end else if (s_ready || (TMO != 0 && age == TMO)) begin
      prev  = grant;
      grant = -1;
    end else begin
      age = age + 1;
    end
  endtask

  function automatic logic [136:0] expected_outputs();
    logic          sv, r0, r1, f0, f1;
    logic [AW-1:0] sa;
    logic [SW-1:0] sw;
    logic [DW-1:0] sd, rd0, rd1;
    sv = 1'b0; r0 = 1'b0; r1 = 1'b0; f0 = 1'b0; f1 = 1'b0;
    sa = '0; sw = '0; sd = '0; rd0 = '0; rd1 = '0;
    if (resetn && grant >= 0) begin
      sa = ma[grant];
      sw = ms[grant];
      sd = md[grant];
      if (!mv[grant]) begin
        sv = 1'b0;
      end else if (s_ready) begin
        sv = 1'b1;
        if (grant == 0) begin r0 = 1'b1; rd0 = s_rdata; end
        else            begin r1 = 1'b1; rd1 = s_rdata; end
      end else if (TMO != 0 && age == TMO) begin
        if (grant == 0) begin r0 = 1'b1; f0 = 1'b1; end
        else            begin r1 = 1'b1; f1 = 1'b1; end
      end else begin
        sv = 1'b1;
      end
    end
    return {sv, sa, sw, sd, r0, rd0, f0, r1, rd1, f1};
  endfunction

  task automatic compare_all();
    logic [136:0] act;
    logic [136:0] exp;
    act = {s_valid, s_addr, s_wstrb, s_wdata, m0_ready, m0_rdata, m0_fault,
           m1_ready, m1_rdata, m1_fault};
    exp = expected_outputs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle_compare t=%0t got=%h expected=%h", $time, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    if (resetn) model_step();
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  task automatic reset_dut();
    resetn  = 1'b0;
    model_reset();
    mv      = 2'b00;
    s_ready = 1'b0;
    next_cycle();
    next_cycle();
    resetn  = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    resetn = 1'b0; mv = 2'b00; s_ready = 1'b0; s_rdata = '0;
    got = 2'b00; stuck = 1'b0;
    for (int i = 0; i < 2; i++) begin ma[i] = '0; ms[i] = '0; md[i] = '0; end
    model_reset();

    // Reset values.
    sample();
    chk("reset_s_valid", 32'(s_valid), 32'd0);
    chk("reset_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("reset_fault", {30'd0, m1_fault, m0_fault}, 32'd0);
    next_cycle(); next_cycle();
    resetn = 1'b1;

    // Single m0 read against a one-cycle slave.
    next_cycle();
    mv[0] = 1'b1; ma[0] = 32'h0000_0100; ms[0] = 4'h0; md[0] = '0;
    sample();
    chk("rd_idle_s_valid", 32'(s_valid), 32'd0);
    next_cycle();
    sample();
    chk("rd_busy_s_valid", 32'(s_valid), 32'd1);
    chk("rd_busy_s_addr", s_addr, 32'h0000_0100);
    next_cycle();
    s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
    sample();
    chk("rd_m0_ready", 32'(m0_ready), 32'd1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("rd_m1_ready", 32'(m1_ready), 32'd0);
    next_cycle();
    mv[0] = 1'b0; s_ready = 1'b0;
    sample();
    chk("rd_after_s_valid", 32'(s_valid), 32'd0);

    // Both held valid from reset: strict alternation starting with m0.
    reset_dut();
    next_cycle();
    mv = 2'b11;
    ma[0] = 32'h0000_00A0; ms[0] = 4'h0;    md[0] = 32'h0;
    ma[1] = 32'h0000_00B0; ms[1] = 4'b0011; md[1] = 32'h1234_5678;
    s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      sample();
      if (c % 2 == 0) begin
        chk("rr_idle_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
      end else if (((c - 1) / 2) % 2 == 0) begin
        chk("rr_m0_grant", {30'd0, m1_ready, m0_ready}, 32'd1);
        chk("rr_m0_addr", s_addr, 32'h0000_00A0);
      end else begin
        chk("rr_m1_grant", {30'd0, m1_ready, m0_ready}, 32'd2);
        chk("rr_m1_wstrb", 32'(s_wstrb), 32'h3);
        chk("rr_m1_wdata", s_wdata, 32'h1234_5678);
      end
    end
    next_cycle();
    mv = 2'b00; s_ready = 1'b0;
    sample();

    // Hung slave: fault on the ninth BUSY cycle, then s_ready on that cycle wins.
    reset_dut();
    next_cycle();
    mv[1] = 1'b1; ma[1] = 32'h0000_0200; ms[1] = 4'h0; s_rdata = 32'hCAFE_F00D;
    sample();
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      sample();
      chk("wd_wait_ready", 32'(m1_ready), 32'd0);
    end
    next_cycle();
    sample();
    chk("wd_fault_ready", 32'(m1_ready), 32'd1);
    chk("wd_fault_flag", 32'(m1_fault), 32'd1);
    chk("wd_fault_rdata", m1_rdata, 32'd0);
    chk("wd_fault_s_valid", 32'(s_valid), 32'd0);
    next_cycle();
    mv[1] = 1'b0;
    sample();
    next_cycle();
    mv[1] = 1'b1;
    sample();
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      sample();
    end
    next_cycle();
    s_ready = 1'b1;
    sample();
    chk("wd_race_ready", 32'(m1_ready), 32'd1);
    chk("wd_race_fault", 32'(m1_fault), 32'd0);
    chk("wd_race_rdata", m1_rdata, 32'hCAFE_F00D);
    next_cycle();
    mv[1] = 1'b0; s_ready = 1'b0;
    sample();

    // Reset during an m0 write, then m0 wins the tie afterwards.
    reset_dut();
    next_cycle();
    mv = 2'b11;
    ma[0] = 32'h0000_0300; ms[0] = 4'hF; md[0] = 32'h55AA_55AA;
    ma[1] = 32'h0000_0400; ms[1] = 4'h1; md[1] = 32'h0000_0011;
    sample();
    next_cycle();
    sample();
    chk("rst_busy_addr", s_addr, 32'h0000_0300);
    next_cycle();
    #2 resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_async_s_valid", 32'(s_valid), 32'd0);
    chk("rst_async_ready", 32'(m0_ready), 32'd0);
    sample();
    next_cycle();
    resetn = 1'b1;
    sample();
    next_cycle();
    sample();
    chk("rst_regrant_addr", s_addr, 32'h0000_0300);
    next_cycle();
    s_ready = 1'b1; s_rdata = 32'h0000_0077;
    sample();
    chk("rst_regrant_ready", 32'(m0_ready), 32'd1);
    next_cycle();
    mv = 2'b00; s_ready = 1'b0;
    sample();

    // m1 abandons its grant; fairness still reflects the earlier m0 win.
    next_cycle();
    mv[1] = 1'b1; ma[1] = 32'h0000_0500;
    sample();
    next_cycle();
    sample();
    chk("drop_busy_addr", s_addr, 32'h0000_0500);
    next_cycle();
    mv[1] = 1'b0;
    sample();
    chk("drop_s_valid", 32'(s_valid), 32'd0);
    chk("drop_ready", 32'(m1_ready), 32'd0);
    next_cycle();
    sample();
    next_cycle();
    mv = 2'b11; ma[0] = 32'h0000_0600; ma[1] = 32'h0000_0700;
    sample();
    next_cycle();
    sample();
    chk("drop_tie_addr", s_addr, 32'h0000_0700);
    next_cycle();
    s_ready = 1'b1;
    sample();
    chk("drop_tie_ready", 32'(m1_ready), 32'd1);
    next_cycle();
    mv = 2'b00; s_ready = 1'b0;
    sample();

    // Random traffic, stuck-slave episodes and occasional async resets.
    got = 2'b00;
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      for (int i = 0; i < 2; i++) begin
        if (mv[i] && (got[i] || $urandom_range(0, 199) == 0)) begin
          mv[i] = 1'b0;
        end else if (!mv[i] && $urandom_range(0, 2) == 0) begin
          mv[i] = 1'b1;
          ma[i] = $urandom;
          ms[i] = SW'($urandom_range(0, 15));
          md[i] = $urandom;
        end
      end
      if ($urandom_range(0, 59) == 0) stuck = ~stuck;
      s_ready = !stuck && ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      if ($urandom_range(0, 699) == 0) begin
        #2 resetn = 1'b0;
        model_reset();
        #1 resetn = 1'b1;
      end
      sample();
      got = {m1_ready, m0_ready};
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
